lm32_dtlb_refill: RTL and testbench

- Hardware refill engine directly downstream of the data TLB.
- Consumes the DTLB miss indication and faulting virtual address, fetches the 32-bit page-table entry (PTE) over a dedicated Wishbone master port, and feeds the DTLB update interface with the new vaddr/paddr pair plus a write strobe.
- On an invalid PTE or a bus error it reports a fault instead, so the CPU raises the DTLB-miss exception only when hardware refill fails.

---
 rtl/lm32_dtlb_refill.sv | 221 ++++++++++++++++++++++
 tb/tb_lm32_dtlb_refill.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lm32_dtlb_refill.sv
// lm32_dtlb_refill: hardware refill engine behind the data TLB.
// On a DTLB miss it reads the PTE over a private Wishbone master port. It then
// either writes the new vaddr/paddr pair into the DTLB or reports a fault.
// Optional feature: define LM32_DTLB_REFILL_TIMEOUT_EN to bound the PTE fetch
// to timeout_cycles (fault cause 3). Without it, FETCH waits indefinitely.
module lm32_dtlb_refill #(
  parameter int page_size      = 4096,
  parameter int timeout_cycles = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        enable,
  input  logic [31:0] ptbr,
  input  logic        miss_req,
  input  logic [31:0] miss_address,
  output logic        busy,
  output logic        tlb_update,
  output logic [31:0] tlb_vaddr,
  output logic [31:0] tlb_paddr,
  output logic        refill_done,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic [31:0] d_adr_o,
  output logic        d_cyc_o,
  output logic        d_stb_o,
  input  logic [31:0] d_dat_i,
  input  logic        d_ack_i,
  input  logic        d_err_i
);

  localparam int          OFF_W    = $clog2(page_size);
  localparam int          VPFN_W   = 32 - OFF_W;
  localparam logic [15:0] TMO_LAST = 16'(timeout_cycles - 1);

  localparam logic [1:0] CAUSE_NOT_PRESENT = 2'd1;
  localparam logic [1:0] CAUSE_BUS_ERR     = 2'd2;
`ifdef LM32_DTLB_REFILL_TIMEOUT_EN
  localparam logic [1:0] CAUSE_TIMEOUT     = 2'd3;
`endif

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_UPDATE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [VPFN_W-1:0]  r_vpfn, w_vpfn_nxt;
  logic               r_abort, w_abort_nxt;
  logic               r_busy, w_busy_nxt;
  logic               r_update, w_update_nxt;
  logic               r_done, w_done_nxt;
  logic               r_fault, w_fault_nxt;
  logic [1:0]         r_cause, w_cause_nxt;
  logic [31:0]        r_vaddr, w_vaddr_nxt;
  logic [31:0]        r_paddr, w_paddr_nxt;
  logic [31:0]        r_adr, w_adr_nxt;
  logic               r_cyc, r_stb, w_cyc_nxt;
  logic [31:0]        w_pte_addr;
  logic               w_unused;
`ifdef LM32_DTLB_REFILL_TIMEOUT_EN
  logic [15:0]        r_tmo_cnt, w_tmo_cnt_nxt;
`endif

  // PTE address: page-aligned table base plus 4 bytes per virtual page, wraps at 2^32.
  assign w_pte_addr = {ptbr[31:OFF_W], {OFF_W{1'b0}}}
                    + {{(OFF_W-2){1'b0}}, miss_address[31:OFF_W], 2'b00};

  // Page-offset bits and PTE flag bits other than valid do not affect the result.
  assign w_unused = ^{ptbr[OFF_W-1:0], miss_address[OFF_W-1:0], d_dat_i[OFF_W-1:1], TMO_LAST};

  assign busy        = r_busy;
  assign tlb_update  = r_update;
  assign tlb_vaddr   = r_vaddr;
  assign tlb_paddr   = r_paddr;
  assign refill_done = r_done;
  assign fault       = r_fault;
  assign fault_cause = r_cause;
  assign d_adr_o     = r_adr;
  assign d_cyc_o     = r_cyc;
  assign d_stb_o     = r_stb;

  // FSM state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and next-output decode for the refill sequence.
  always_comb begin
    w_state_nxt   = r_state;
    w_vpfn_nxt    = r_vpfn;
    w_abort_nxt   = r_abort;
    w_update_nxt  = 1'b0;
    w_done_nxt    = 1'b0;
    w_fault_nxt   = 1'b0;
    w_cause_nxt   = r_cause;
    w_vaddr_nxt   = r_vaddr;
    w_paddr_nxt   = r_paddr;
    w_adr_nxt     = r_adr;
    w_cyc_nxt     = r_cyc;
`ifdef LM32_DTLB_REFILL_TIMEOUT_EN
    w_tmo_cnt_nxt = r_tmo_cnt;
`endif
    case (r_state)
      S_IDLE: begin
        if (enable && miss_req) begin
          w_state_nxt   = S_FETCH;
          w_vpfn_nxt    = miss_address[31:OFF_W];
          w_abort_nxt   = 1'b0;
          w_adr_nxt     = w_pte_addr;
          w_cyc_nxt     = 1'b1;
`ifdef LM32_DTLB_REFILL_TIMEOUT_EN
          w_tmo_cnt_nxt = 16'd0;
`endif
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_FETCH: begin
        if (d_ack_i || d_err_i) begin
          w_cyc_nxt = 1'b0;
          if (r_abort || !enable) begin
            // MMU switched off mid-fetch: finish the bus cycle, drop the result.
            w_state_nxt = S_IDLE;
          end else if (d_err_i) begin
            w_state_nxt = S_IDLE;
            w_fault_nxt = 1'b1;
            w_cause_nxt = CAUSE_BUS_ERR;
          end else if (d_dat_i[0]) begin
            w_state_nxt  = S_UPDATE;
            w_update_nxt = 1'b1;
            w_vaddr_nxt  = {r_vpfn, {OFF_W{1'b0}}};
            w_paddr_nxt  = {d_dat_i[31:OFF_W], {OFF_W{1'b0}}};
          end else begin
            w_state_nxt = S_IDLE;
            w_fault_nxt = 1'b1;
            w_cause_nxt = CAUSE_NOT_PRESENT;
          end
        end else begin
          w_abort_nxt = r_abort | ~enable;
`ifdef LM32_DTLB_REFILL_TIMEOUT_EN
          if (r_tmo_cnt == TMO_LAST) begin
            w_cyc_nxt   = 1'b0;
            w_state_nxt = S_IDLE;
            if (r_abort || !enable) begin
              w_fault_nxt = 1'b0;
            end else begin
              w_fault_nxt = 1'b1;
              w_cause_nxt = CAUSE_TIMEOUT;
            end
          end else begin
            w_tmo_cnt_nxt = r_tmo_cnt + 16'd1;
          end
`else
          w_state_nxt = S_FETCH;
`endif
        end
      end
      S_UPDATE: begin
        w_state_nxt = S_DONE;
        w_done_nxt  = 1'b1;
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cyc_nxt   = 1'b0;
      end
    endcase
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  // Output and datapath registers; bus strobes fall asynchronously on reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_vpfn   <= {VPFN_W{1'b0}};
      r_abort  <= 1'b0;
      r_busy   <= 1'b0;
      r_update <= 1'b0;
      r_done   <= 1'b0;
      r_fault  <= 1'b0;
      r_cause  <= 2'd0;
      r_vaddr  <= 32'd0;
      r_paddr  <= 32'd0;
      r_adr    <= 32'd0;
      r_cyc    <= 1'b0;
      r_stb    <= 1'b0;
    end else begin
      r_vpfn   <= w_vpfn_nxt;
      r_abort  <= w_abort_nxt;
      r_busy   <= w_busy_nxt;
      r_update <= w_update_nxt;
      r_done   <= w_done_nxt;
      r_fault  <= w_fault_nxt;
      r_cause  <= w_cause_nxt;
      r_vaddr  <= w_vaddr_nxt;
      r_paddr  <= w_paddr_nxt;
      r_adr    <= w_adr_nxt;
      r_cyc    <= w_cyc_nxt;
      r_stb    <= w_cyc_nxt;
    end
  end

`ifdef LM32_DTLB_REFILL_TIMEOUT_EN
  // Fetch watchdog counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_tmo_cnt <= 16'd0;
    end else begin
      r_tmo_cnt <= w_tmo_cnt_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_lm32_dtlb_refill.sv
// Testbench for lm32_dtlb_refill: directed vector table, hand-written
// multi-cycle sequences, and randomized refills checked against a model.
module tb_lm32_dtlb_refill;

  localparam int PAGE = 4096;

  logic        clk_i, rst_i, enable, miss_req;
  logic [31:0] ptbr, miss_address, d_dat_i;
  logic        d_ack_i, d_err_i;
  logic        busy, tlb_update, refill_done, fault, d_cyc_o, d_stb_o;
  logic [31:0] tlb_vaddr, tlb_paddr, d_adr_o;
  logic [1:0]  fault_cause;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [1:0]  last_cause;

  typedef struct {
    logic [31:0] ptbr;
    logic [31:0] addr;
    logic [31:0] dat;
    int          lat;
    logic        ack;
    logic        err;
    int          drop;       // 0 none, 1 enable low during FETCH, 2 enable low in UPDATE
    logic [31:0] exp_adr;
    logic        exp_update;
    logic [31:0] exp_vaddr;
    logic [31:0] exp_paddr;
    logic        exp_fault;
    logic [1:0]  exp_cause;
  } vec_t;

  vec_t tbl [8];

  lm32_dtlb_refill #(.page_size(PAGE), .timeout_cycles(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .enable(enable), .ptbr(ptbr),
    .miss_req(miss_req), .miss_address(miss_address), .busy(busy),
    .tlb_update(tlb_update), .tlb_vaddr(tlb_vaddr), .tlb_paddr(tlb_paddr),
    .refill_done(refill_done), .fault(fault), .fault_cause(fault_cause),
    .d_adr_o(d_adr_o), .d_cyc_o(d_cyc_o), .d_stb_o(d_stb_o),
    .d_dat_i(d_dat_i), .d_ack_i(d_ack_i), .d_err_i(d_err_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: derives the expected outcome from plain page arithmetic.
  function automatic vec_t model(input vec_t v);
    vec_t        r;
    logic [63:0] sum;
    r = v;
    sum = ({32'd0, v.ptbr} / 64'(PAGE)) * 64'(PAGE) + ({32'd0, v.addr} / 64'(PAGE)) * 64'd4;
    r.exp_adr    = sum[31:0];
    r.exp_vaddr  = (v.addr / 32'(PAGE)) * 32'(PAGE);
    r.exp_paddr  = (v.dat / 32'(PAGE)) * 32'(PAGE);
    r.exp_update = 1'b0;
    r.exp_fault  = 1'b0;
    r.exp_cause  = 2'd0;
    if (v.drop == 1) begin
      r.exp_update = 1'b0;
    end else if (v.err) begin
      r.exp_fault = 1'b1;
      r.exp_cause = 2'd2;
    end else if (v.dat % 32'd2 == 32'd1) begin
      r.exp_update = 1'b1;
    end else begin
      r.exp_fault = 1'b1;
      r.exp_cause = 2'd1;
    end
    return r;
  endfunction

  // One complete refill attempt, checking every cycle of the protocol.
  task automatic apply(input vec_t v, input string tag);
    @(posedge clk_i); #1;
    ptbr = v.ptbr; miss_address = v.addr; miss_req = 1'b1; enable = 1'b1;
    @(posedge clk_i); #1;
    miss_req = 1'b0;
    if (v.drop == 1) enable = 1'b0;
    @(negedge clk_i);
    chk({tag, ".cyc"}, 32'(d_cyc_o), 32'd1);
    chk({tag, ".stb"}, 32'(d_stb_o), 32'd1);
    chk({tag, ".adr"}, d_adr_o, v.exp_adr);
    chk({tag, ".busy"}, 32'(busy), 32'd1);
    for (int i = 0; i < v.lat; i++) begin
      @(posedge clk_i);
      @(negedge clk_i);
      chk({tag, ".cyc_hold"}, 32'(d_cyc_o), 32'd1);
    end
    d_ack_i = v.ack; d_err_i = v.err; d_dat_i = v.dat;
    @(posedge clk_i); #1;
    d_ack_i = 1'b0; d_err_i = 1'b0; d_dat_i = $urandom;
    if (v.drop == 2) enable = 1'b0;
    @(negedge clk_i);
    chk({tag, ".cyc_drop"}, 32'(d_cyc_o), 32'd0);
    chk({tag, ".stb_drop"}, 32'(d_stb_o), 32'd0);
    chk({tag, ".update"}, 32'(tlb_update), 32'(v.exp_update));
    chk({tag, ".fault"}, 32'(fault), 32'(v.exp_fault));
    chk({tag, ".done_early"}, 32'(refill_done), 32'd0);
    chk({tag, ".busy_ack"}, 32'(busy), 32'(v.exp_update));
    if (v.exp_fault) last_cause = v.exp_cause;
    chk({tag, ".cause"}, 32'(fault_cause), 32'(last_cause));
    if (v.exp_update) begin
      chk({tag, ".vaddr"}, tlb_vaddr, v.exp_vaddr);
      chk({tag, ".paddr"}, tlb_paddr, v.exp_paddr);
      @(negedge clk_i);
      chk({tag, ".done"}, 32'(refill_done), 32'd1);
      chk({tag, ".update_once"}, 32'(tlb_update), 32'd0);
      chk({tag, ".busy_done"}, 32'(busy), 32'd1);
      @(negedge clk_i);
      chk({tag, ".busy_after"}, 32'(busy), 32'd0);
      chk({tag, ".done_once"}, 32'(refill_done), 32'd0);
    end else begin
      @(negedge clk_i);
      chk({tag, ".fault_once"}, 32'(fault), 32'd0);
      chk({tag, ".no_update"}, 32'(tlb_update), 32'd0);
      chk({tag, ".no_done"}, 32'(refill_done), 32'd0);
    end
    enable = 1'b1;
  endtask

  initial begin
    vec_t rv;
    // ptbr, addr, dat, lat, ack, err, drop | adr, upd, vaddr, paddr, flt, cause
    tbl[0] = '{32'h0010_0000, 32'h0040_3ABC, 32'h1234_5001, 2, 1'b1, 1'b0, 0,
               32'h0010_100C, 1'b1, 32'h0040_3000, 32'h1234_5000, 1'b0, 2'd0};
    tbl[1] = '{32'h0010_0000, 32'h0040_3ABC, 32'h1234_5000, 2, 1'b1, 1'b0, 0,
               32'h0010_100C, 1'b0, 32'h0, 32'h0, 1'b1, 2'd1};
    tbl[2] = '{32'h0010_0000, 32'h0040_3ABC, 32'h1234_5001, 1, 1'b1, 1'b1, 0,
               32'h0010_100C, 1'b0, 32'h0, 32'h0, 1'b1, 2'd2};
    tbl[3] = '{32'hFFFF_F000, 32'hFFFF_F000, 32'hABCD_E001, 0, 1'b1, 1'b0, 0,
               32'h003F_EFFC, 1'b1, 32'hFFFF_F000, 32'hABCD_E000, 1'b0, 2'd0};
    tbl[4] = '{32'h0020_0FFF, 32'h0000_0123, 32'h0000_1FFF, 1, 1'b1, 1'b0, 0,
               32'h0020_0000, 1'b1, 32'h0000_0000, 32'h0000_1000, 1'b0, 2'd0};
    tbl[5] = '{32'h8000_0000, 32'h1234_5678, 32'hFFFF_FFFF, 3, 1'b0, 1'b1, 0,
               32'h8004_8D14, 1'b0, 32'h0, 32'h0, 1'b1, 2'd2};
    tbl[6] = '{32'h0010_0000, 32'h0040_3ABC, 32'h1234_5001, 1, 1'b1, 1'b0, 1,
               32'h0010_100C, 1'b0, 32'h0, 32'h0, 1'b0, 2'd0};
    tbl[7] = '{32'h0030_0000, 32'h0000_1000, 32'h7654_3211, 0, 1'b1, 1'b0, 2,
               32'h0030_0004, 1'b1, 32'h0000_1000, 32'h7654_3000, 1'b0, 2'd0};

    rst_i = 1'b1; enable = 1'b0; miss_req = 1'b0; ptbr = 32'd0; miss_address = 32'd0;
    d_dat_i = 32'd0; d_ack_i = 1'b0; d_err_i = 1'b0; last_cause = 2'd0;

    // Reset state.
    #12;
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.cyc", 32'(d_cyc_o), 32'd0);
    chk("rst.stb", 32'(d_stb_o), 32'd0);
    chk("rst.adr", d_adr_o, 32'd0);
    chk("rst.out", {26'd0, tlb_update, refill_done, fault, fault_cause, 1'b0}, 32'd0);
    chk("rst.vaddr", tlb_vaddr, 32'd0);
    chk("rst.paddr", tlb_paddr, 32'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    enable = 1'b1;

    // Directed table.
    for (int i = 0; i < 8; i++) apply(tbl[i], $sformatf("vec%0d", i));

    // Asynchronous reset in the middle of a fetch, then a clean refill.
    @(posedge clk_i); #1;
    ptbr = 32'h0010_0000; miss_address = 32'h0040_3ABC; miss_req = 1'b1;
    @(posedge clk_i); #1;
    miss_req = 1'b0;
    @(negedge clk_i);
    chk("arst.cyc_before", 32'(d_cyc_o), 32'd1);
    #2 rst_i = 1'b1;
    #1;
    chk("arst.cyc", 32'(d_cyc_o), 32'd0);
    chk("arst.stb", 32'(d_stb_o), 32'd0);
    chk("arst.busy", 32'(busy), 32'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    last_cause = 2'd0;
    @(negedge clk_i);
    chk("arst.quiet", {29'd0, tlb_update, fault, d_cyc_o}, 32'd0);
    apply(tbl[0], "arst.refill");

    // miss_req held high: ignored while busy, re-accepted after refill_done.
    @(posedge clk_i); #1;
    ptbr = 32'h0010_0000; miss_address = 32'h0040_3ABC; miss_req = 1'b1;
    @(posedge clk_i); #1;
    miss_address = 32'h0080_0123;
    @(negedge clk_i);
    chk("b2b.adr", d_adr_o, 32'h0010_100C);
    d_ack_i = 1'b1; d_dat_i = 32'h0000_5001;
    @(posedge clk_i); #1;
    d_ack_i = 1'b0;
    @(negedge clk_i);
    chk("b2b.update", 32'(tlb_update), 32'd1);
    chk("b2b.vaddr", tlb_vaddr, 32'h0040_3000);
    chk("b2b.adr_hold", d_adr_o, 32'h0010_100C);
    @(negedge clk_i);
    chk("b2b.done", 32'(refill_done), 32'd1);
    @(negedge clk_i);
    chk("b2b.idle", 32'(busy), 32'd0);
    @(negedge clk_i);
    chk("b2b.cyc2", 32'(d_cyc_o), 32'd1);
    chk("b2b.adr2", d_adr_o, 32'h0010_2000);
    miss_req = 1'b0; d_ack_i = 1'b1; d_dat_i = 32'h0000_0000;
    @(posedge clk_i); #1;
    d_ack_i = 1'b0;
    @(negedge clk_i);
    chk("b2b.fault", 32'(fault), 32'd1);
    chk("b2b.cause", 32'(fault_cause), 32'd1);
    last_cause = 2'd1;

`ifdef LM32_DTLB_REFILL_TIMEOUT_EN
    // Timeout after four FETCH cycles, then a late ack is ignored.
    @(posedge clk_i); #1;
    miss_address = 32'h0000_7000; miss_req = 1'b1;
    @(posedge clk_i); #1;
    miss_req = 1'b0;
    @(negedge clk_i);
    chk("tmo.cyc0", 32'(d_cyc_o), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_i);
      @(negedge clk_i);
      chk("tmo.cyc_hold", 32'(d_cyc_o), 32'd1);
    end
    @(posedge clk_i);
    @(negedge clk_i);
    chk("tmo.cyc", 32'(d_cyc_o), 32'd0);
    chk("tmo.fault", 32'(fault), 32'd1);
    chk("tmo.cause", 32'(fault_cause), 32'd3);
    chk("tmo.busy", 32'(busy), 32'd0);
    last_cause = 2'd3;
    d_ack_i = 1'b1; d_dat_i = 32'h0000_9001;
    @(posedge clk_i); #1;
    d_ack_i = 1'b0;
    @(negedge clk_i);
    chk("tmo.late", {29'd0, tlb_update, busy, fault}, 32'd0);
`else
    // No watchdog: the fetch waits as long as the slave stays silent.
    @(posedge clk_i); #1;
    miss_address = 32'h0000_7000; miss_req = 1'b1;
    @(posedge clk_i); #1;
    miss_req = 1'b0;
    repeat (1000) @(posedge clk_i);
    @(negedge clk_i);
    chk("hang.busy", 32'(busy), 32'd1);
    chk("hang.cyc", 32'(d_cyc_o), 32'd1);
    chk("hang.fault", 32'(fault), 32'd0);
    d_err_i = 1'b1;
    @(posedge clk_i); #1;
    d_err_i = 1'b0;
    @(negedge clk_i);
    chk("hang.err_fault", 32'(fault), 32'd1);
    chk("hang.cause", 32'(fault_cause), 32'd2);
    last_cause = 2'd2;
`endif

    // Randomized refills against the reference model.
    for (int i = 0; i < 60; i++) begin
      rv.ptbr = $urandom;
      rv.addr = $urandom;
      rv.dat  = $urandom;
      rv.lat  = int'($urandom_range(0, 4));
      rv.err  = ($urandom_range(0, 4) == 0);
      rv.ack  = rv.err ? 1'($urandom_range(0, 1)) : 1'b1;
      rv.drop = ($urandom_range(0, 9) == 0) ? 1 : (($urandom_range(0, 9) == 0) ? 2 : 0);
      rv = model(rv);
      apply(rv, $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
